// File: rtl/fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// fetch_stage_pkg
// Constants and types shared by the instruction fetch stage and its branch
// target buffer.
//   NOP_INST        : pipeline bubble encoding shown on f_inst when not valid
//   CTR_WEAK_TAKEN  : counter value given to a freshly allocated BTB entry
//   btb_entry_t     : one BTB entry (valid, tag, target, 2-bit counter)
//   ctr_update()    : 2-bit saturating counter step
// Optional feature macro used by the fetch stage: BRANCH_PRED_EN
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST       = 32'h0000_0001;
  localparam logic [1:0]  CTR_WEAK_TAKEN = 2'b10;

  // Widest possible tag (BTB with a single entry); narrower tags are
  // zero-extended into this field.
  localparam int BTB_TAG_MAX_W = 30;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [31:0]              target;
    logic [1:0]               ctr;
  } btb_entry_t;

  // Saturating step: up on taken, down on not taken, clamped to [0,3].
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr,
                                            input logic       taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fetch_stage_btb.sv
// ----------------------------------------------------------------------------
// fetch_stage_btb
// Direct-mapped branch target buffer with 2^IDX_W entries. Built only when
// BRANCH_PRED_EN is defined.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset (clears valids)
//   lookup_pc          : PC being predicted (combinational lookup)
//   lookup_taken       : entry valid, tag match and counter MSB set
//   lookup_target      : stored target of the indexed entry
//   upd_valid          : training strobe from a resolved branch
//   upd_pc             : PC of the resolved branch
//   upd_taken          : resolved outcome
//   upd_target         : resolved taken target
// Lookup is asynchronous so the prediction can steer next_pc in the same
// cycle; a lookup and an update to the same index see pre-update contents.
// ----------------------------------------------------------------------------
`ifdef BRANCH_PRED_EN
module fetch_stage_btb
  import fetch_stage_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  // Only valid bits are cleared; tag/target/counter storage has no reset.
  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [31:0]      r_target [DEPTH];
  logic [1:0]       r_ctr    [DEPTH];

  logic [IDX_W-1:0] w_lu_idx;
  logic [TAG_W-1:0] w_lu_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_alloc;
  logic [DEPTH-1:0] w_set_valid;
  btb_entry_t       w_lu_entry;
  btb_entry_t       w_upd_entry;
  logic             w_unused_bits;

  assign w_lu_idx  = lookup_pc[IDX_W+1:2];
  assign w_lu_tag  = lookup_pc[31:IDX_W+2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[31:IDX_W+2];

  // Byte-offset bits never select anything.
  assign w_unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  always_comb begin
    w_lu_entry        = '0;
    w_lu_entry.valid  = r_valid[w_lu_idx];
    w_lu_entry.tag    = BTB_TAG_MAX_W'(r_tag[w_lu_idx]);
    w_lu_entry.target = r_target[w_lu_idx];
    w_lu_entry.ctr    = r_ctr[w_lu_idx];
  end

  always_comb begin
    w_upd_entry        = '0;
    w_upd_entry.valid  = r_valid[w_upd_idx];
    w_upd_entry.tag    = BTB_TAG_MAX_W'(r_tag[w_upd_idx]);
    w_upd_entry.target = r_target[w_upd_idx];
    w_upd_entry.ctr    = r_ctr[w_upd_idx];
  end

  assign lookup_taken  = w_lu_entry.valid &&
                         (w_lu_entry.tag == BTB_TAG_MAX_W'(w_lu_tag)) &&
                         w_lu_entry.ctr[1];
  assign lookup_target = w_lu_entry.target;

  assign w_upd_hit = w_upd_entry.valid &&
                     (w_upd_entry.tag == BTB_TAG_MAX_W'(w_upd_tag));
  // A not-taken miss is not worth an entry; only taken misses allocate.
  assign w_alloc   = upd_valid && !w_upd_hit && upd_taken;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_set_valid
    assign w_set_valid[gi] = w_alloc && (w_upd_idx == IDX_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= r_valid | w_set_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_valid) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= ctr_update(w_upd_entry.ctr, upd_taken);
        if (upd_taken) r_target[w_upd_idx] <= upd_target;
      end else if (upd_taken) begin
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_ctr[w_upd_idx]    <= CTR_WEAK_TAKEN;
      end
    end
  end

endmodule
`endif

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: owns the PC, drives a synchronous-read instruction
// memory and presents f_pc/f_inst to the fetch/decode pipeline register.
// Optional branch prediction via BTB when BRANCH_PRED_EN is defined.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : hold the current fetch outputs
//   redirect        : fetch redirect_pc next (overrides stall)
//   redirect_pc     : redirect target
//   upd_valid/pc/taken/target : BTB training (ignored without BRANCH_PRED_EN)
//   imem_addr       : combinational word address, registered in the memory
//   imem_rdata      : instruction for the address of the previous edge
//   f_pc, f_inst    : fetched PC and instruction (NOP_INST when not valid)
//   f_valid         : f_inst is a real fetch
//   f_pred_taken    : BTB predicts taken for f_pc
//   f_pred_npc      : predicted next PC for f_pc
// ----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 14,
  parameter int          BTB_IDX  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic               upd_taken,
  input  logic [31:0]        upd_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        f_pc,
  output logic [31:0]        f_inst,
  output logic               f_valid,
  output logic               f_pred_taken,
  output logic [31:0]        f_pred_npc
);

  // r_pc is the PC whose instruction is currently on imem_rdata.
  logic [31:0] r_pc;
  logic        r_valid;

  logic [31:0] w_seq_pc;
  logic        w_pred_taken;
  logic [31:0] w_pred_npc;
  logic [31:0] w_next_pc;

  // Wraps modulo 2^32 by construction.
  assign w_seq_pc = r_pc + 32'd4;

`ifdef BRANCH_PRED_EN
  logic        w_btb_taken;
  logic [31:0] w_btb_target;

  fetch_stage_btb #(
    .IDX_W (BTB_IDX)
  ) btb_u (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (r_pc),
    .lookup_taken  (w_btb_taken),
    .lookup_target (w_btb_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target)
  );

  assign w_pred_taken = w_btb_taken;
  assign w_pred_npc   = w_btb_taken ? w_btb_target : w_seq_pc;
`else
  logic w_unused_upd;

  assign w_unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};
  assign w_pred_taken = 1'b0;
  assign w_pred_npc   = w_seq_pc;
`endif

  // Redirect beats stall. While not yet valid the reset PC is re-read so the
  // first real fetch lines up with its memory data. Under reset the memory
  // address is pinned to RESET_PC regardless of other inputs.
  always_comb begin
    w_next_pc = w_pred_npc;
    if (rst) begin
      w_next_pc = RESET_PC;
    end else if (redirect) begin
      w_next_pc = redirect_pc;
    end else if (stall || !r_valid) begin
      w_next_pc = r_pc;
    end
  end

  assign imem_addr = w_next_pc[IMEM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_next_pc;
      r_valid <= 1'b1;
    end
  end

  assign f_pc         = r_pc;
  assign f_valid      = r_valid;
  assign f_inst       = r_valid ? imem_rdata : NOP_INST;
  assign f_pred_taken = w_pred_taken;
  assign f_pred_npc   = w_pred_npc;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int          AW    = 14;
  localparam int          BN    = 64;
  localparam logic [31:0] NOP_W = 32'h0000_0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          upd_valid = 1'b0;
  logic [31:0]   upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic [31:0]   upd_target = '0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   f_pc;
  logic [31:0]   f_inst;
  logic          f_valid;
  logic          f_pred_taken;
  logic [31:0]   f_pred_npc;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(AW), .BTB_IDX(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .f_pc         (f_pc),
    .f_inst       (f_inst),
    .f_valid      (f_valid),
    .f_pred_taken (f_pred_taken),
    .f_pred_npc   (f_pred_npc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] x;
    x = (32'(a) + 32'd1) * 32'h9E37_79B1;
    return x ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_bv   [BN];
  logic [31:0] m_btag [BN];
  logic [31:0] m_btgt [BN];
  int          m_bctr [BN];

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(BN));
  endfunction

  function automatic logic [31:0] btag(input logic [31:0] pc);
    return pc / (32'd4 * 32'(BN));
  endfunction

  function automatic bit model_taken();
`ifdef BRANCH_PRED_EN
    int i;
    i = bidx(m_pc);
    return m_bv[i] && (m_btag[i] == btag(m_pc)) && (m_bctr[i] >= 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_npc();
    if (model_taken()) return m_btgt[bidx(m_pc)];
    return m_pc + 32'd4;
  endfunction

  function automatic logic [31:0] model_next();
    if (redirect) return redirect_pc;
    if (stall || !m_valid) return m_pc;
    return model_npc();
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [31:0] pc);
    return AW'(pc / 32'd4);
  endfunction

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    for (int i = 0; i < BN; i++) m_bv[i] = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] nxt;
    nxt = model_next();
`ifdef BRANCH_PRED_EN
    if (upd_valid) begin
      int i;
      bit hit;
      i   = bidx(upd_pc);
      hit = m_bv[i] && (m_btag[i] == btag(upd_pc));
      if (hit) begin
        if (upd_taken) begin
          if (m_bctr[i] < 3) m_bctr[i]++;
          m_btgt[i] = upd_target;
        end else if (m_bctr[i] > 0) begin
          m_bctr[i]--;
        end
      end else if (upd_taken) begin
        m_bv[i]   = 1'b1;
        m_btag[i] = btag(upd_pc);
        m_btgt[i] = upd_target;
        m_bctr[i] = 2;
      end
    end
`endif
    m_pc    = nxt;
    m_valid = 1'b1;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit s, input bit r, input logic [31:0] rp,
                        input bit uv, input logic [31:0] up, input bit ut,
                        input logic [31:0] utg);
    stall = s; redirect = r; redirect_pc = rp;
    upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid got=%b exp=0", f_valid); end
    checks++; if (f_inst !== NOP_W) begin errors++; $display("FAIL reset_f_inst got=%h exp=%h", f_inst, NOP_W); end
    checks++; if (f_pc !== 32'h0) begin errors++; $display("FAIL reset_f_pc got=%h exp=0", f_pc); end
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got=%b exp=0", f_pred_taken); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL seq_first_valid got=%b exp=0", f_valid); end
    cycle();
    for (int k = 0; k < 3; k++) begin
      checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL seq_valid k=%0d got=%b exp=1", k, f_valid); end
      checks++; if (f_pc !== 32'(4 * k)) begin errors++; $display("FAIL seq_f_pc k=%0d got=%h exp=%h", k, f_pc, 32'(4 * k)); end
      checks++; if (f_inst !== mem_word(AW'(k))) begin errors++; $display("FAIL seq_f_inst k=%0d got=%h exp=%h", k, f_inst, mem_word(AW'(k))); end
      if (k < 2) cycle();
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 4; c++) begin
      set_in(c < 3, 0, 0, 0, 0, 0, 0);
      checks++; if (f_pc !== 32'h8) begin errors++; $display("FAIL stall_f_pc c=%0d got=%h exp=8", c, f_pc); end
      checks++; if (f_inst !== mem_word(2)) begin errors++; $display("FAIL stall_f_inst c=%0d got=%h exp=%h", c, f_inst, mem_word(2)); end
      checks++; if (f_pred_npc !== 32'hC) begin errors++; $display("FAIL stall_npc c=%0d got=%h exp=c", c, f_pred_npc); end
      cycle();
    end
    checks++; if (f_pc !== 32'hC) begin errors++; $display("FAIL stall_release_pc got=%h exp=c", f_pc); end
    checks++; if (f_inst !== mem_word(3)) begin errors++; $display("FAIL stall_release_inst got=%h exp=%h", f_inst, mem_word(3)); end
  endtask

  task automatic test_redirect();
    set_in(1, 1, 32'h40, 0, 0, 0, 0);
    checks++; if (imem_addr !== AW'(16)) begin errors++; $display("FAIL redir_imem_addr got=%h exp=10", imem_addr); end
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++; if (f_pc !== 32'h40) begin errors++; $display("FAIL redir_f_pc got=%h exp=40", f_pc); end
    checks++; if (f_inst !== mem_word(16)) begin errors++; $display("FAIL redir_f_inst got=%h exp=%h", f_inst, mem_word(16)); end
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL redir_f_valid got=%b exp=1", f_valid); end
  endtask

  task automatic test_btb();
    set_in(0, 0, 0, 1, 32'h10, 1, 32'h80);
    cycle();
    set_in(0, 1, 32'h10, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
`ifdef BRANCH_PRED_EN
    checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL btb_taken got=%b exp=1", f_pred_taken); end
    checks++; if (f_pred_npc !== 32'h80) begin errors++; $display("FAIL btb_npc got=%h exp=80", f_pred_npc); end
    cycle();
    checks++; if (f_pc !== 32'h80) begin errors++; $display("FAIL btb_follow_pc got=%h exp=80", f_pc); end
    checks++; if (f_inst !== mem_word(AW'(32))) begin errors++; $display("FAIL btb_follow_inst got=%h exp=%h", f_inst, mem_word(AW'(32))); end
    set_in(0, 0, 0, 1, 32'h10, 0, 0);
    cycle();
    cycle();
    set_in(0, 1, 32'h10, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
`endif
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL btb_nt_taken got=%b exp=0", f_pred_taken); end
    checks++; if (f_pred_npc !== 32'h14) begin errors++; $display("FAIL btb_nt_npc got=%h exp=14", f_pred_npc); end
    cycle();
    checks++; if (f_pc !== 32'h14) begin errors++; $display("FAIL btb_nt_pc got=%h exp=14", f_pc); end
  endtask

  task automatic test_wrap();
    set_in(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++; if (f_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_f_pc got=%h exp=fffffffc", f_pc); end
    checks++; if (f_pred_npc !== 32'h0) begin errors++; $display("FAIL wrap_npc got=%h exp=0", f_pred_npc); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL wrap_imem_addr got=%h exp=0", imem_addr); end
    cycle();
    checks++; if (f_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc got=%h exp=0", f_pc); end
    checks++; if (f_inst !== mem_word(0)) begin errors++; $display("FAIL wrap_next_inst got=%h exp=%h", f_inst, mem_word(0)); end
  endtask

  task automatic test_random();
    logic [31:0] rp, up, ut, exp_inst, exp_npc;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) rp = $urandom & 32'hFFFF_FFFC;
      else rp = 32'($urandom_range(0, 127)) * 32'd4;
      up = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
      ut = 32'($urandom_range(0, 255)) * 32'd4;
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, rp,
             $urandom_range(0, 2) == 0, up, $urandom_range(0, 2) != 0, ut);
      exp_inst = m_valid ? mem_word(word_of(m_pc)) : NOP_W;
      exp_npc  = model_npc();
      checks++; if (f_pc !== m_pc) begin errors++; $display("FAIL rand_f_pc n=%0d got=%h exp=%h", n, f_pc, m_pc); end
      checks++; if (f_valid !== m_valid) begin errors++; $display("FAIL rand_f_valid n=%0d got=%b exp=%b", n, f_valid, m_valid); end
      checks++; if (f_inst !== exp_inst) begin errors++; $display("FAIL rand_f_inst n=%0d got=%h exp=%h", n, f_inst, exp_inst); end
      checks++; if (f_pred_taken !== model_taken()) begin errors++; $display("FAIL rand_pred_taken n=%0d got=%b exp=%b", n, f_pred_taken, model_taken()); end
      checks++; if (f_pred_npc !== exp_npc) begin errors++; $display("FAIL rand_pred_npc n=%0d got=%h exp=%h", n, f_pred_npc, exp_npc); end
      checks++; if (imem_addr !== word_of(model_next())) begin errors++; $display("FAIL rand_imem_addr n=%0d got=%h exp=%h", n, imem_addr, word_of(model_next())); end
      cycle();
    end
  endtask

  task automatic test_async_reset();
    set_in(0, 0, 0, 1, 32'h10, 1, 32'h80);
    cycle();
    set_in(1, 1, 32'h200, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL arst_f_valid got=%b exp=0", f_valid); end
    checks++; if (f_inst !== NOP_W) begin errors++; $display("FAIL arst_f_inst got=%h exp=%h", f_inst, NOP_W); end
    checks++; if (f_pc !== 32'h0) begin errors++; $display("FAIL arst_f_pc got=%h exp=0", f_pc); end
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL arst_pred_taken got=%b exp=0", f_pred_taken); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL arst_imem_addr got=%h exp=0", imem_addr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    set_in(0, 1, 32'h10, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++; if (f_pc !== 32'h10) begin errors++; $display("FAIL arst_redir_pc got=%h exp=10", f_pc); end
    checks++; if (f_inst !== mem_word(4)) begin errors++; $display("FAIL arst_redir_inst got=%h exp=%h", f_inst, mem_word(4)); end
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL arst_btb_forgot got=%b exp=0", f_pred_taken); end
    checks++; if (f_pred_npc !== 32'h14) begin errors++; $display("FAIL arst_btb_npc got=%h exp=14", f_pred_npc); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_btb();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that produces `f_pc`/`f_inst` for the fetch/decode pipeline register. It owns the program counter and drives a synchronous-read instruction memory. It accepts stall and redirect requests from the hazard/execute logic. It optionally predicts taken branches with a small branch target buffer (BTB) trained from the execute/writeback side.

## Interface
Parameters:
- `RESET_PC`, 32'h0: first fetched address after reset.
- `IMEM_AW`, 14: instruction memory word-address width.
- `BTB_IDX`, 6: log2 of BTB entry count.

Ports:
- `clk`  in  1: the only clock; everything is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hold the current fetch output (downstream register not updating).
- `redirect`  in  1: fetch from `redirect_pc` next. Asserted on jump, jr or mispredict.
- `redirect_pc`  in  32: redirect target.
- `upd_valid`  in  1: BTB training strobe (resolved branch).
- `upd_pc`  in  32: PC of the resolved branch.
- `upd_taken`  in  1: branch outcome.
- `upd_target`  in  32: resolved taken target.
- `imem_addr`  out  IMEM_AW: memory word address. Combinational; registered inside the memory.
- `imem_rdata`  in  32: instruction for the address sampled at the previous edge.
- `f_pc`  out  32: PC of `f_inst`.
- `f_inst`  out  32: fetched instruction; `NOP_INST` when `f_valid`=0.
- `f_valid`  out  1: `f_inst` is a real fetch.
- `f_pred_taken`  out  1: BTB predicted taken for `f_pc`.
- `f_pred_npc`  out  32: predicted next PC for `f_pc`.

## Operation
- State:
  - `pc_q`: PC whose instruction is on `imem_rdata`.
  - `valid_q`: output valid.
  - BTB arrays, present only when the feature is compiled in.
- `next_pc` is selected by priority:
  1. `redirect` → `redirect_pc`.
  2. `stall` or `!valid_q` → `pc_q`.
  3. Otherwise → `f_pred_npc`.
- `imem_addr` = `next_pc[IMEM_AW+1:2]`.
- On each edge: `pc_q` <= `next_pc`, and `valid_q` <= 1.
- Stall: the same address is re-read each cycle, so `f_inst` stays stable without a skid buffer. The instruction memory is read-only here.
- Redirect overrides stall. The wrong-path instruction shown in the redirect cycle is flushed downstream, not here.
- Outputs:
  - `f_pc` = `pc_q`.
  - `f_inst` = `valid_q` ? `imem_rdata` : `NOP_INST`.
- `f_pred_npc` = predicted ? BTB target : `pc_q + 32'd4`. The +4 add is modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- BTB (direct-mapped, 2^BTB_IDX entries):
  - Index = `pc[BTB_IDX+1:2]`; tag = `pc[31:BTB_IDX+2]`.
  - Each entry holds valid, tag, target and a 2-bit saturating counter.
  - Predict taken when the entry is valid, the tag matches and `counter[1]`=1.
- BTB training on `upd_valid`:
  - Tag hit: counter is incremented if taken, decremented if not, saturating at 3 and 0. Target is written when taken.
  - Miss and taken: allocate the entry with counter 2'b10 and the target.
  - Miss and not taken: no change.
- Simultaneous lookup and update of the same index: the lookup sees the pre-update contents; the write lands at the edge.

## Timing
- Reset (async) values:
  - `pc_q`=`RESET_PC`, `valid_q`=0, all BTB valid bits 0. Targets, tags and counters are not reset.
  - During reset: `f_valid`=0, `f_inst`=`NOP_INST`, `f_pc`=`RESET_PC`, `f_pred_taken`=0, `imem_addr`=`RESET_PC[IMEM_AW+1:2]`.
- First edge after reset release: `valid_q` becomes 1 and `pc_q` stays `RESET_PC`. From the next cycle `f_pc`=`RESET_PC` with its instruction.
- Redirect asserted in cycle N → `f_pc`=`redirect_pc` with its instruction in cycle N+1, `f_valid`=1.
- Stall asserted in cycle N → all `f_*` outputs in N+1 equal those in N. This holds until the cycle after stall drops.
- A BTB update in cycle N affects predictions from cycle N+1.
- Reset asserted mid-stall or mid-redirect returns all state to reset values immediately.

## Configuration
- `BRANCH_PRED_EN` defined: BTB is built and behaves as above.
- Undefined: no BTB storage; `f_pred_taken`=0, `f_pred_npc`=`f_pc+4`, and the `upd_*` inputs are ignored (ports remain).

## Structure
- Shared constants package gets:
  - `NOP_INST` = 32'h1, the pipeline bubble encoding.
  - A BTB entry struct type: valid, tag, target, counter.
  - Counter reset value `CTR_WEAK_TAKEN` = 2'b10.
- Sub-module `btb` holds the lookup port, update port and async-cleared valid vector. It is instantiated only under `BRANCH_PRED_EN`.

## Test plan
- Reset release, no stall → `f_valid`=0 then `f_pc` = 0, 4, 8, … on consecutive cycles, with `f_inst` matching memory words 0, 1, 2.
- Stall for 3 cycles while `f_pc`=8 → `f_pc`=8 and `f_inst`=mem[2] held for 4 cycles, then 12.
- `redirect`=1 with `redirect_pc`=0x40 and `stall`=1 in the same cycle → next cycle `f_pc`=0x40, `f_inst`=mem[16].
- With `BRANCH_PRED_EN`: `upd_valid`, `upd_pc`=0x10, `upd_taken`=1, `upd_target`=0x80 → at the next fetch of 0x10, `f_pred_taken`=1, `f_pred_npc`=0x80, and the following `f_pc`=0x80. Two not-taken updates → `f_pred_taken`=0.
- `pc_q`=32'hFFFFFFFC, no prediction → `f_pred_npc`=0 and the next `f_pc`=0.
- Assert `rst` asynchronously mid-stream → outputs go to reset values immediately, without a clock edge, and the BTB forgets trained entries.
